// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared widths and transmitter state encoding for the TRNG UART path
package trng_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/trng_word_fifo.sv
// rtl/trng_word_fifo.sv - synchronous word FIFO; a push while full is accepted only alongside a pop
module trng_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_i);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap through their natural width; DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level_q <= level_q + 1'b1;
            end else if (!push_ok && pop_ok) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/trng_uart_tx.sv
// rtl/trng_uart_tx.sv - buffers TRNG words and sends each as 4 UART bytes, MSB byte first
// Optional even-parity framing (8E1) when TRNG_TX_PARITY_EN is defined; 8N1 otherwise.
module trng_uart_tx
    import trng_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115_200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WORD_W-1:0]           word_in,
    input  logic                        word_valid,
    output logic                        tx,
    output logic                        busy,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t          state_q;
    logic [BAUD_W-1:0]  baud_q;
    logic [2:0]         bit_q;
    logic [1:0]         byte_q;
    logic [WORD_W-1:0]  word_q;
    logic               tx_q;
    logic               busy_q;
    logic               overrun_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic [WORD_W-1:0]  fifo_rdata;
    logic               pop;
    logic               bit_end;
    logic [BYTE_W-1:0]  cur_byte;
    logic               tx_d;

    trng_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (word_valid),
        .wdata_i (word_in),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign pop      = (state_q == IDLE) && !fifo_empty;
    assign bit_end  = (baud_q == BAUD_LAST);
    // ~byte_q equals 3-byte_q, so byte 0 selects bits [31:24].
    assign cur_byte = word_q[{~byte_q, 3'b000} +: BYTE_W];

    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_q];
            PARITY:  tx_d = ^cur_byte;
            default: tx_d = 1'b1;
        endcase
    end

    // The line and busy flag are registered from the current state, so both trail it by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            word_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            tx_q      <= tx_d;
            busy_q    <= (state_q != IDLE);
            overrun_q <= overrun_q | (word_valid & fifo_full & ~pop);
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (pop) begin
                        word_q  <= fifo_rdata;
                        byte_q  <= '0;
                        bit_q   <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        bit_q  <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef TRNG_TX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef TRNG_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        state_q <= STOP;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (byte_q == 2'(BYTES_PER_WORD - 1)) begin
                            state_q <= IDLE;
                        end else begin
                            byte_q  <= byte_q + 2'd1;
                            state_q <= START;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_trng_uart_tx.sv
// tb/tb_trng_uart_tx.sv - directed bench for trng_uart_tx at 10 clocks per bit, 4-word FIFO
module tb_trng_uart_tx;

`ifdef TRNG_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int WAIT_BUDGET = 600;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] word_in;
    logic        word_valid;
    wire         tx;
    wire         busy;
    wire         overrun;
    wire  [2:0]  fifo_level;

    int vectors = 0;
    int miscompares = 0;

    trng_uart_tx #(
        .CLK_FREQ_HZ (1000),
        .BAUD        (100),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_in    (word_in),
        .word_valid (word_valid),
        .tx         (tx),
        .busy       (busy),
        .overrun    (overrun),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        word_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] w);
        word_in = w;
        word_valid = 1'b1;
        @(posedge clk);
        #1 word_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, output logic par, output logic ok);
        int n;
        b = '0;
        par = 1'b0;
        ok = 1'b1;
        n = 0;
        while (tx !== 1'b0 && n < WAIT_BUDGET) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= WAIT_BUDGET) begin
            ok = 1'b0;
        end else begin
            repeat (4) @(posedge clk);
            #1;
            if (tx !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (10) @(posedge clk);
                #1 b[i] = tx;
            end
`ifdef TRNG_TX_PARITY_EN
            repeat (10) @(posedge clk);
            #1 par = tx;
`endif
            repeat (10) @(posedge clk);
            #1;
            if (tx !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic recv_word(output logic [31:0] w, output logic ok);
        logic [7:0] b;
        logic       p;
        logic       okb;
        w = '0;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            recv_byte(b, p, okb);
            w = {w[23:0], b};
            ok = ok & okb;
        end
    endtask

    task automatic count_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) lows++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        word_valid = 1'b0;
        word_in = '0;
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b expected 1", tx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_word();
        logic [7:0] exp_b [4];
        logic [7:0] b;
        logic       p;
        logic       ok;
        int         busy_cnt;
        exp_b[0] = 8'hA5; exp_b[1] = 8'hC3; exp_b[2] = 8'h0F; exp_b[3] = 8'h81;
        do_reset();
        strobe(32'hA5C30F81);
        vectors++; if (fifo_level !== 3'd1) begin miscompares++; $display("FAIL single_level_push: got %0d expected 1", fifo_level); end
        @(posedge clk);
        #1;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_n1: got %b expected 1", tx); end
        vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL single_level_pop: got %0d expected 0", fifo_level); end
        @(posedge clk);
        #1;
        vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL single_tx_n2: got %b expected 0", tx); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_n2: got %b expected 1", busy); end
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    recv_byte(b, p, ok);
                    vectors++; if (b !== exp_b[k]) begin miscompares++; $display("FAIL single_byte%0d: got %h expected %h", k, b, exp_b[k]); end
                    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL single_frame%0d: got %b expected 1", k, ok); end
                end
            end
            begin
                busy_cnt = 0;
                while (busy === 1'b1 && busy_cnt < 1000) begin
                    busy_cnt++;
                    @(posedge clk);
                    #1;
                end
            end
        join
        vectors++; if (busy_cnt !== 40 * FRAME_BITS) begin miscompares++; $display("FAIL single_busy_len: got %0d expected %0d", busy_cnt, 40 * FRAME_BITS); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL single_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_burst_overrun();
        logic [31:0] w [6];
        logic [31:0] got;
        logic        ok;
        int          lows;
        w[0] = 32'h11223344; w[1] = 32'h55667788; w[2] = 32'h99AABBCC;
        w[3] = 32'hDDEEFF00; w[4] = 32'h0F1E2D3C; w[5] = 32'hDEADBEEF;
        do_reset();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    if (i == 5) begin
                        vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL burst_level_full: got %0d expected 4", fifo_level); end
                        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL burst_overrun_before: got %b expected 0", overrun); end
                    end
                    strobe(w[i]);
                    repeat (31) @(posedge clk);
                    #1;
                end
                vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL burst_overrun_after: got %b expected 1", overrun); end
                vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL burst_level_after: got %0d expected 4", fifo_level); end
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    recv_word(got, ok);
                    vectors++; if (got !== w[k] || ok !== 1'b1) begin miscompares++; $display("FAIL burst_word%0d: got %h ok %b expected %h ok 1", k, got, ok, w[k]); end
                end
            end
        join
        count_low(600, lows);
        vectors++; if (lows !== 0) begin miscompares++; $display("FAIL burst_no_sixth: got %0d low cycles expected 0", lows); end
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL burst_overrun_sticky: got %b expected 1", overrun); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] w [6];
        logic [31:0] got;
        logic        ok;
        w[0] = 32'hA0A0A0A0; w[1] = 32'h0B0B0B0B; w[2] = 32'hC1C2C3C4;
        w[3] = 32'h12345678; w[4] = 32'h87654321; w[5] = 32'hF00DCAFE;
        do_reset();
        strobe(w[0]);
        for (int i = 1; i < 5; i++) begin
            repeat (19) @(posedge clk);
            #1;
            strobe(w[i]);
        end
        vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL fullpop_level_filled: got %0d expected 4", fifo_level); end
        repeat (321) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fullpop_busy_last: got %b expected 1", busy); end
        strobe(w[5]);
        vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL fullpop_level_same: got %0d expected 4", fifo_level); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL fullpop_overrun: got %b expected 0", overrun); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL fullpop_busy_gap: got %b expected 0", busy); end
        for (int k = 1; k < 6; k++) begin
            recv_word(got, ok);
            vectors++; if (got !== w[k] || ok !== 1'b1) begin miscompares++; $display("FAIL fullpop_word%0d: got %h ok %b expected %h ok 1", k, got, ok, w[k]); end
        end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL fullpop_overrun_end: got %b expected 0", overrun); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0]  b;
        logic        p;
        logic        ok;
        logic [31:0] got;
        int          n;
        int          lows;
        do_reset();
        fork
            begin
                strobe(32'hC3A5007E);
                recv_byte(b, p, ok);
                vectors++; if (b !== 8'hC3 || ok !== 1'b1) begin miscompares++; $display("FAIL rstmid_byte0: got %h ok %b expected c3 ok 1", b, ok); end
                recv_byte(b, p, ok);
                vectors++; if (b !== 8'hA5 || ok !== 1'b1) begin miscompares++; $display("FAIL rstmid_byte1: got %h ok %b expected a5 ok 1", b, ok); end
            end
            begin
                repeat (50) @(posedge clk);
                #1;
                for (int i = 0; i < 5; i++) strobe(32'h01010101 * (i + 1));
                vectors++; if (fifo_level !== 3'd4 || overrun !== 1'b1) begin miscompares++; $display("FAIL rstmid_prefill: got level %0d overrun %b expected 4 1", fifo_level, overrun); end
            end
        join
        n = 0;
        while (tx !== 1'b0 && n < WAIT_BUDGET) begin
            @(posedge clk);
            #1 n++;
        end
        repeat (25) @(posedge clk);
        #1;
        vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL rstmid_in_data: got %b expected 0", tx); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rstmid_overrun: got %b expected 0", overrun); end
        vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL rstmid_level: got %0d expected 0", fifo_level); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        count_low(100, lows);
        vectors++; if (lows !== 0) begin miscompares++; $display("FAIL rstmid_residual: got %0d low cycles expected 0", lows); end
        strobe(32'h96E13C5A);
        recv_word(got, ok);
        vectors++; if (got !== 32'h96E13C5A || ok !== 1'b1) begin miscompares++; $display("FAIL rstmid_next_word: got %h ok %b expected 96e13c5a ok 1", got, ok); end
        count_low(500, lows);
        vectors++; if (lows !== 0) begin miscompares++; $display("FAIL rstmid_extra: got %0d low cycles expected 0", lows); end
    endtask

`ifdef TRNG_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] b;
        logic       p;
        logic       ok;
        do_reset();
        strobe(32'h01000000);
        recv_byte(b, p, ok);
        vectors++; if (b !== 8'h01 || p !== 1'b1 || ok !== 1'b1) begin miscompares++; $display("FAIL parity_byte0: got %h par %b ok %b expected 01 par 1 ok 1", b, p, ok); end
        recv_byte(b, p, ok);
        vectors++; if (b !== 8'h00 || p !== 1'b0 || ok !== 1'b1) begin miscompares++; $display("FAIL parity_byte1: got %h par %b ok %b expected 00 par 0 ok 1", b, p, ok); end
        recv_byte(b, p, ok);
        recv_byte(b, p, ok);
        vectors++; if (b !== 8'h00 || p !== 1'b0 || ok !== 1'b1) begin miscompares++; $display("FAIL parity_byte3: got %h par %b ok %b expected 00 par 0 ok 1", b, p, ok); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_burst_overrun();
        test_full_push_pop();
        test_reset_mid_frame();
`ifdef TRNG_TX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
